// File: rtl/execute_memory_register.sv
// execute_memory_register: EX/MEM pipeline register with stall, flush and sync reset
module execute_memory_register #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  wbs_in,
    input  logic                  wme_in,
    input  logic                  mm_in,
    input  logic                  wm_in,
    input  logic                  ni_in,
    input  logic [DATA_WIDTH-1:0] ALUresult_in,
    input  logic [DATA_WIDTH-1:0] memData_in,
    output logic                  wbs_out,
    output logic                  wme_out,
    output logic                  mm_out,
    output logic                  wm_out,
    output logic                  ni_out,
    output logic [DATA_WIDTH-1:0] ALUresult_out,
    output logic [DATA_WIDTH-1:0] memData_out
);
    localparam int W = 5 + 2 * DATA_WIDTH;
    logic [W-1:0] stage_d, stage_q;
    always_comb begin
        stage_d = (rst || flush) ? '0
                : en ? {wbs_in, wme_in, mm_in, wm_in, ni_in, ALUresult_in, memData_in}
                : stage_q;
    end
    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end
    assign {wbs_out, wme_out, mm_out, wm_out, ni_out, ALUresult_out, memData_out} = stage_q;
endmodule

// File: tb/tb_execute_memory_register.sv
// tb_execute_memory_register: table-driven check of load, stall, flush and reset priority
module tb_execute_memory_register;
    logic clk = 1'b0;
    logic rst, en, flush;
    logic wbs_in, wme_in, mm_in, wm_in, ni_in;
    logic [15:0] ALUresult_in, memData_in;
    logic wbs_out, wme_out, mm_out, wm_out, ni_out;
    logic [15:0] ALUresult_out, memData_out;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    execute_memory_register #(.DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in), .wm_in(wm_in), .ni_in(ni_in),
        .ALUresult_in(ALUresult_in), .memData_in(memData_in),
        .wbs_out(wbs_out), .wme_out(wme_out), .mm_out(mm_out), .wm_out(wm_out), .ni_out(ni_out),
        .ALUresult_out(ALUresult_out), .memData_out(memData_out)
    );

    typedef struct {
        logic        r, f, e;
        logic [4:0]  fl;
        logic [15:0] a, m;
        logic [4:0]  efl;
        logic [15:0] ea, em;
    } vec_t;

    vec_t v[14];

    function automatic logic [36:0] outs();
        return {wbs_out, wme_out, mm_out, wm_out, ni_out, ALUresult_out, memData_out};
    endfunction

    task automatic check(input string name, input int idx, input logic [36:0] exp);
        logic [36:0] act;
        act = outs();
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got flags=%b alu=%h mem=%h, expected flags=%b alu=%h mem=%h",
                     name, idx, act[36:32], act[31:16], act[15:0], exp[36:32], exp[31:16], exp[15:0]);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic e, input logic [4:0] fl,
                         input logic [15:0] a, input logic [15:0] m);
        rst = r; flush = f; en = e;
        {wbs_in, wme_in, mm_in, wm_in, ni_in} = fl;
        ALUresult_in = a; memData_in = m;
    endtask

    initial begin
        logic [36:0] prev;
        // {wbs,wme,mm,wm,ni}; load1 = 10111/1234/ABCD, load2 = 01000/4A81/7755
        v[0]  = '{1, 0, 1, 5'b11111, 16'hFFFF, 16'hFFFF, 5'b00000, 16'h0000, 16'h0000};
        v[1]  = '{0, 0, 1, 5'b10111, 16'h1234, 16'hABCD, 5'b10111, 16'h1234, 16'hABCD};
        v[2]  = '{0, 0, 1, 5'b01000, 16'h4A81, 16'h7755, 5'b01000, 16'h4A81, 16'h7755};
        v[3]  = '{0, 0, 0, 5'b11111, 16'hFFFF, 16'hFFFF, 5'b01000, 16'h4A81, 16'h7755};
        v[4]  = '{0, 0, 0, 5'b11111, 16'hFFFF, 16'hFFFF, 5'b01000, 16'h4A81, 16'h7755};
        v[5]  = '{0, 0, 0, 5'b11111, 16'hFFFF, 16'hFFFF, 5'b01000, 16'h4A81, 16'h7755};
        v[6]  = '{0, 0, 1, 5'b11111, 16'hFFFF, 16'hFFFF, 5'b11111, 16'hFFFF, 16'hFFFF};
        v[7]  = '{0, 0, 1, 5'b10111, 16'h1234, 16'hABCD, 5'b10111, 16'h1234, 16'hABCD};
        v[8]  = '{0, 1, 1, 5'b11111, 16'h5A5A, 16'hA5A5, 5'b00000, 16'h0000, 16'h0000};
        v[9]  = '{0, 0, 1, 5'b10111, 16'h1234, 16'hABCD, 5'b10111, 16'h1234, 16'hABCD};
        v[10] = '{0, 1, 0, 5'b11111, 16'h5A5A, 16'hA5A5, 5'b00000, 16'h0000, 16'h0000};
        v[11] = '{0, 0, 1, 5'b01000, 16'h4A81, 16'h7755, 5'b01000, 16'h4A81, 16'h7755};
        v[12] = '{1, 1, 1, 5'b11111, 16'hFFFF, 16'hFFFF, 5'b00000, 16'h0000, 16'h0000};
        v[13] = '{0, 0, 1, 5'b01000, 16'h4A81, 16'h7755, 5'b01000, 16'h4A81, 16'h7755};
        drive(0, 0, 0, 5'b0, 16'h0, 16'h0);
        prev = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(v[i].r, v[i].f, v[i].e, v[i].fl, v[i].a, v[i].m);
            #1;
            if (i > 0) check("pre_edge_hold", i, prev);
            @(posedge clk);
            #1;
            prev = {v[i].efl, v[i].ea, v[i].em};
            check("post_edge", i, prev);
        end
        // reset raised between edges must not act until the next rising edge
        @(negedge clk);
        drive(0, 0, 1, 5'b10111, 16'h1234, 16'hABCD);
        @(posedge clk);
        #1;
        check("reload", 0, {5'b10111, 16'h1234, 16'hABCD});
        #2;
        drive(1, 0, 1, 5'b11111, 16'hFFFF, 16'hFFFF);
        #1;
        check("rst_mid_hold", 0, {5'b10111, 16'h1234, 16'hABCD});
        @(negedge clk);
        check("rst_mid_hold", 1, {5'b10111, 16'h1234, 16'hABCD});
        @(posedge clk);
        #1;
        check("rst_mid_clear", 0, 37'h0);
        @(negedge clk);
        drive(0, 0, 1, 5'b11111, 16'hFFFF, 16'hFFFF);
        @(posedge clk);
        #1;
        check("after_rst_load", 0, {5'b11111, 16'hFFFF, 16'hFFFF});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/execute_memory_register.md
Name: execute_memory_register

Overview:
- Execute-to-Memory (EX/MEM) pipeline register of the 16-bit CPU datapath.
- Captures the Execute stage's ALU result, store data and control flags on each rising clock edge.
- Presents these values unchanged to the Memory and Writeback stages for one full cycle.
- Supports stall (hold) and flush (bubble insertion) in addition to reset.

Parameters:
- DATA_WIDTH, 16, width of ALUresult and memData paths.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous to clk, active-high.
- en  input  1  load enable; 1 = capture inputs, 0 = hold (stall).
- flush  input  1  synchronous bubble insert; clears all stored fields.
- wbs_in  input  1  writeback source select from Execute.
- wme_in  input  1  write-memory enable from Execute.
- mm_in  input  1  memory/ALU result mux select from Execute.
- wm_in  input  1  register-file write flag from Execute.
- ni_in  input  1  new/valid-instruction flag from Execute.
- ALUresult_in  input  DATA_WIDTH  ALU result; also used as memory address.
- memData_in  input  DATA_WIDTH  store data for data memory.
- wbs_out  output  1  registered wbs_in.
- wme_out  output  1  registered wme_in.
- mm_out  output  1  registered mm_in.
- wm_out  output  1  registered wm_in.
- ni_out  output  1  registered ni_in.
- ALUresult_out  output  DATA_WIDTH  registered ALUresult_in.
- memData_out  output  DATA_WIDTH  registered memData_in.

Behaviour:
- All outputs driven directly from flip-flops; no combinational path from any input to any output.
- Update priority at each rising clk edge: rst > flush > en.
- rst=1: every output becomes 0 (all flags 0, ALUresult_out=0, memData_out=0).
  - Synchronous: asserting rst between edges does not change outputs until the next edge.
  - Overrides flush and en.
- rst=0, flush=1: all outputs cleared to 0 regardless of en.
  - The resulting bubble must not write memory (wme_out=0) or the register file (wm_out=0).
- rst=0, flush=0, en=1: every output takes the value its matching input had at that edge.
- rst=0, flush=0, en=0: all outputs hold their previous values.
- Latency: exactly one clock cycle from input to output; a value applied before edge N is visible after edge N and stays stable until edge N+1.
- All fields load together.
  - No partial updates; control and data fields always belong to the same instruction.
- Data fields are passed bit-exact; no sign extension, truncation or arithmetic.
- Power-up state before the first reset is undefined; the system must apply rst before use.
- Simultaneous input changes and a clock edge use standard setup semantics: the value present before the edge is captured.

Test Plan:
- Reset: rst=1 for one edge with all inputs nonzero -> all outputs 0; deassert rst, en=1 -> next edge loads the inputs.
- Load 1: en=1; wbs=1, wme=0, mm=1, wm=1, ni=1, ALUresult_in=0x1234, memData_in=0xABCD.
  - After one edge: wbs_out=1, wme_out=0, mm_out=1, wm_out=1, ni_out=1, ALUresult_out=0x1234, memData_out=0xABCD.
  - Outputs unchanged before that edge.
- Load 2, back-to-back: wbs=0, wme=1, mm=0, wm=0, ni=0, ALUresult_in=0x4A81, memData_in=0x7755.
  - After the next edge, outputs match exactly.
  - No residual bits from Load 1.
- Stall: after Load 2, set en=0, change inputs to 0xFFFF and all flags 1 -> outputs stay 0x4A81/0x7755 with flags 0,1,0,0,0 for 3 edges; re-assert en -> 0xFFFF/all-ones appears after one edge.
- Flush: outputs holding 0x1234/0xABCD, flush=1 with en=1 and nonzero inputs -> after the edge all outputs 0; flush=1 with en=0 also clears.
- Priority: rst=1 and flush=1 and en=1 together -> all outputs 0; rst pulsed mid-stream between edges -> outputs change only at the next rising edge.
